toast_dmem_arbiter: RTL
=======================

Name: toast_dmem_arbiter

Overview:
Shares the single data-memory port between the core's MEM stage and a transformer accelerator/DMA requester. The MEM stage has fixed priority. The accelerator is served in idle slots, and gets a forced slot after MAX_WAIT cycles of starvation, which stalls the core. The block tracks the one-cycle read latency and routes each returning word to the requester that issued the read.

Parameters:
MAX_WAIT, 8, consecutive denied accelerator cycles before a forced accelerator slot (1..255)
CNT_W, 8, width of the starvation counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cpu_req_i  in  1  MEM stage performs a load/store this cycle
cpu_we_i  in  1  MEM stage store
cpu_addr_i  in  32  MEM stage byte address
cpu_wdata_i  in  32  MEM stage store data, already lane-aligned
cpu_stall_o  out  1  core must hold EX/MEM; access not performed this cycle
cpu_rdata_o  out  32  read data for the MEM stage, one cycle after grant
acc_valid_i  in  1  accelerator request valid
acc_ready_o  out  1  accelerator request accepted this cycle
acc_we_i  in  1  accelerator write
acc_addr_i  in  32  accelerator byte address; must be word aligned
acc_wdata_i  in  32  accelerator write data
acc_rvalid_o  out  1  acc_rdata_o valid
acc_rdata_o  out  32  accelerator read data
acc_err_o  out  1  one-cycle pulse: misaligned accelerator request dropped
DMEM_addr_o  out  32  word address {addr[31:2],2'b00}
DMEM_wr_en_o  out  1  write enable
DMEM_ce_o  out  1  chip enable, high only on a granted access
DMEM_wr_data_o  out  32  write data
DMEM_rd_data_i  in  32  memory read data, one-cycle latency

Behaviour:
- Registered state: wait_cnt[CNT_W], rd_owner {NONE, CPU, ACC}, acc_err_o. On reset all are 0/NONE, and the combinational outputs settle to idle: ce=0, wr_en=0, stall=0, ready=0, addr=0, wdata=0.
- Grant, combinational, evaluated in order each cycle:
  - FORCE: acc_valid_i and wait_cnt==MAX_WAIT → grant ACC. cpu_stall_o=cpu_req_i.
  - CPU: cpu_req_i → grant CPU. acc_ready_o=0.
  - ACC: acc_valid_i → grant ACC.
  - Otherwise no grant: ce=0.
- On a granted access, DMEM_ce_o=1 and addr/we/wdata are muxed from the winner. DMEM_wr_en_o is high only when the winner's we is 1.
- Misaligned accelerator request (acc_addr_i[1:0]!=0) while it would be granted:
  - acc_ready_o=1, so the request is consumed.
  - ce=0 for that access.
  - acc_err_o pulses on the next cycle.
  - The request counts as an acc grant for the counter.
- Starvation counter:
  - Clears on an acc grant or when acc_valid_i=0.
  - Otherwise increments, saturating at MAX_WAIT.
  - After a FORCE grant, the next slot follows normal priority, so at most one stall per MAX_WAIT+1 cycles.
- Read return: a granted read sets rd_owner to the winner; any other cycle sets rd_owner to NONE.
  - acc_rvalid_o = (rd_owner==ACC) and is high for exactly one cycle per read.
  - cpu_rdata_o and acc_rdata_o are both driven from DMEM_rd_data_i. cpu_rdata_o is valid when rd_owner==CPU.
- Writes produce no return.
- Back-to-back reads from alternating owners are legal. The owner pipeline is one deep, so there are no read-data bubbles.
- Simultaneous cpu_req_i and acc_valid_i with wait_cnt<MAX_WAIT: CPU wins, and the accelerator holds its request (valid/data stable until ready).
- Reset asserted mid-read: rd_owner goes to NONE immediately, and the returning word is discarded (no rvalid).

Decomposition:
- Shared package toast_definitions.vh gains the owner encoding constants OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_ACC=2'd2, plus the default MAX_WAIT.
- One natural sub-module: toast_starve_counter (saturating counter with clear and hit flag).

Test Plan:
1. CPU read only: cpu_req_i=1, we=0, addr=0x104 → DMEM_ce_o=1, DMEM_addr_o=0x104, stall=0. Next cycle cpu_rdata_o equals the memory word and acc_rvalid_o=0.
2. Idle CPU, acc write addr=0x200, data=0xDEADBEEF → ready=1, DMEM_wr_en_o=1 the same cycle. A later acc read of 0x200 gives acc_rvalid_o=1 with 0xDEADBEEF one cycle after ready.
3. Contention, MAX_WAIT=3, cpu_req_i held high, acc_valid_i high → ready=0 for cycles 0-2. Cycle 3: ready=1 and cpu_stall_o=1. Cycle 4: CPU granted, stall=0, and the counter restarts.
4. Alternating reads: cycle 0 CPU read 0x10, cycle 1 acc read 0x20 → cycle 1 cpu_rdata_o holds the word at 0x10, and cycle 2 acc_rvalid_o=1 with the word at 0x20.
5. Misaligned acc addr=0x202 → ready=1, DMEM_ce_o=0, acc_err_o=1 for exactly one cycle next, no rvalid.
6. Assert rst_i during a granted acc read → acc_rvalid_o stays 0. All outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/toast_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-owner encoding and defaults.
package toast_dmem_arbiter_pkg;

  // Who issued the read whose data arrives on the memory port this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_ACC  = 2'd2
  } owner_e;

  localparam int DEFAULT_MAX_WAIT = 8;
  localparam int DEFAULT_CNT_W    = 8;

  // The memory is word organised; byte lanes are already handled by the requester
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/toast_starve_counter.sv
// Saturating starvation counter: counts denied accelerator cycles, flags when the limit is hit.
module toast_starve_counter #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;

  // Clear wins; otherwise count up and park at the limit until the accelerator is served
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != MAX_CNT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == MAX_CNT);

endmodule

// File: rtl/toast_dmem_arbiter.sv
// Data-memory port arbiter between the core MEM stage and the accelerator/DMA requester.
// MEM stage has priority; a starved accelerator gets one forced slot that stalls the core.
module toast_dmem_arbiter
  import toast_dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        acc_valid_i,
  output logic        acc_ready_o,
  input  logic        acc_we_i,
  input  logic [31:0] acc_addr_i,
  input  logic [31:0] acc_wdata_i,
  output logic        acc_rvalid_o,
  output logic [31:0] acc_rdata_o,
  output logic        acc_err_o,
  output logic [31:0] DMEM_addr_o,
  output logic        DMEM_wr_en_o,
  output logic        DMEM_ce_o,
  output logic [31:0] DMEM_wr_data_o,
  input  logic [31:0] DMEM_rd_data_i
);

  owner_e grant;
  owner_e rd_owner;
  owner_e rd_owner_next;
  logic   starve_hit;
  logic   force_slot;
  logic   acc_misaligned;
  logic   cnt_clr;

  assign acc_misaligned = (acc_addr_i[1:0] != 2'b00);

  // Winner selection: starved accelerator first, then MEM stage, then accelerator in idle slots
  always_comb begin
    grant      = OWN_NONE;
    force_slot = 1'b0;
    if (!rst_i) begin
      if (acc_valid_i && starve_hit) begin
        grant      = OWN_ACC;
        force_slot = 1'b1;
      end else if (cpu_req_i) begin
        grant = OWN_CPU;
      end else if (acc_valid_i) begin
        grant = OWN_ACC;
      end
    end
  end

  assign cpu_stall_o = force_slot & cpu_req_i;
  assign acc_ready_o = (grant == OWN_ACC);

  // Memory port mux; a consumed misaligned accelerator request leaves the port idle
  always_comb begin
    DMEM_ce_o      = 1'b0;
    DMEM_wr_en_o   = 1'b0;
    DMEM_addr_o    = '0;
    DMEM_wr_data_o = '0;
    case (grant)
      OWN_CPU: begin
        DMEM_ce_o      = 1'b1;
        DMEM_wr_en_o   = cpu_we_i;
        DMEM_addr_o    = word_addr(cpu_addr_i);
        DMEM_wr_data_o = cpu_wdata_i;
      end
      OWN_ACC: begin
        if (!acc_misaligned) begin
          DMEM_ce_o      = 1'b1;
          DMEM_wr_en_o   = acc_we_i;
          DMEM_addr_o    = word_addr(acc_addr_i);
          DMEM_wr_data_o = acc_wdata_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Only a performed read has data coming back next cycle
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (DMEM_ce_o && !DMEM_wr_en_o) begin
      rd_owner_next = grant;
    end
  end

  // Track the read in flight and flag dropped misaligned requests one cycle later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_owner  <= OWN_NONE;
      acc_err_o <= 1'b0;
    end else begin
      rd_owner  <= rd_owner_next;
      acc_err_o <= acc_ready_o & acc_misaligned;
    end
  end

  // Starvation restarts whenever the accelerator is served or stops asking
  assign cnt_clr = acc_ready_o | ~acc_valid_i;

  toast_starve_counter #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_starve (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (cnt_clr),
    .hit  (starve_hit)
  );

  assign acc_rvalid_o = (rd_owner == OWN_ACC);
  assign cpu_rdata_o  = DMEM_rd_data_i;
  assign acc_rdata_o  = DMEM_rd_data_i;

endmodule
